pipe_mult_rv: RTL and testbench



---
 rtl/pipe_mult_pkg.sv | 23 ++
 rtl/pipe_mult_stage.sv | 67 ++++++
 rtl/pipe_mult_rv.sv | 91 +++++++++
 tb/tb_pipe_mult_rv.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mult_pkg.sv
// rtl/pipe_mult_pkg.sv - multiply mode encodings and operand-signedness helpers
package pipe_mult_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_MUL    = 2'b00;
  localparam mode_t MODE_MULH   = 2'b01;
  localparam mode_t MODE_MULHSU = 2'b10;
  localparam mode_t MODE_MULHU  = 2'b11;

  function automatic logic hi_select(input mode_t mode);
    return mode != MODE_MUL;
  endfunction

  function automatic logic a_signed(input mode_t mode);
    return (mode == MODE_MULH) || (mode == MODE_MULHSU);
  endfunction

  function automatic logic b_signed(input mode_t mode);
    return mode == MODE_MULH;
  endfunction

endpackage

// File: rtl/pipe_mult_stage.sv
// rtl/pipe_mult_stage.sv - one pipeline stage: adds chunk IDX of the multiplier times the multiplicand
module pipe_mult_stage
  import pipe_mult_pkg::*;
#(
  parameter int EW    = 40,
  parameter int CW    = 5,
  parameter int IDX   = 0,
  parameter int TAG_W = 4,
  parameter bit LAST  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [2*EW-1:0]   in_acc,
  input  logic [EW-1:0]     in_a,
  input  logic [2*EW-1:0]   in_b,
  output logic              out_valid,
  output logic [1:0]        out_mode,
  output logic [TAG_W-1:0]  out_tag,
  output logic [2*EW-1:0]   out_acc,
  output logic [EW-1:0]     out_a,
  output logic [2*EW-1:0]   out_b
);

  logic [CW-1:0]   chunk;
  logic [2*EW-1:0] chunk_x;
  logic [2*EW-1:0] partial;
  logic [2*EW-1:0] acc_nxt;

  // The top chunk carries the operand's sign weight, so it is sign-extended; lower chunks are unsigned.
  always_comb begin
    chunk   = in_a[IDX*CW +: CW];
    chunk_x = {{(2*EW-CW){LAST && chunk[CW-1]}}, chunk};
    partial = chunk_x * in_b;
    acc_nxt = in_acc + (partial << (IDX*CW));
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
    end
  end

  // Only the final stage clears its data, since it drives the visible result.
  always_ff @(posedge clk) begin
    if (LAST && rst) begin
      out_mode <= MODE_MUL;
      out_tag  <= '0;
      out_acc  <= '0;
      out_a    <= '0;
      out_b    <= '0;
    end else if (en) begin
      out_mode <= in_mode;
      out_tag  <= in_tag;
      out_acc  <= acc_nxt;
      out_a    <= in_a;
      out_b    <= in_b;
    end
  end

endmodule

// File: rtl/pipe_mult_rv.sv
// rtl/pipe_mult_rv.sv - pipelined RV M-extension multiplier with valid/ready, flush and tag
module pipe_mult_rv
  import pipe_mult_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 8,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        mode_i,
  input  logic [WIDTH-1:0]  multiplier_i,
  input  logic [WIDTH-1:0]  multicand_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WIDTH-1:0]  product_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              busy_o
);

  // ceil((WIDTH+1)/STAGES): one spare bit so unsigned operands keep a zero sign bit
  localparam int CW = (WIDTH + STAGES) / STAGES;
  localparam int EW = CW * STAGES;

  logic stall;
  logic en;
  logic accept;

  logic             v   [0:STAGES];
  logic [1:0]       m   [0:STAGES];
  logic [TAG_W-1:0] t   [0:STAGES];
  logic [2*EW-1:0]  acc [0:STAGES];
  logic [EW-1:0]    a   [0:STAGES];
  logic [2*EW-1:0]  b   [0:STAGES];

  assign stall   = valid_o & ~ready_i;
  assign en      = ~stall;
  assign ready_o = ~stall & ~rst;
  assign accept  = valid_i & ready_o & ~flush_i;

  assign v[0]   = accept;
  assign m[0]   = mode_i;
  assign t[0]   = tag_i;
  assign acc[0] = '0;
  assign a[0]   = {{(EW-WIDTH){a_signed(mode_i) & multiplier_i[WIDTH-1]}}, multiplier_i};
  assign b[0]   = {{(2*EW-WIDTH){b_signed(mode_i) & multicand_i[WIDTH-1]}}, multicand_i};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_mult_stage #(
      .EW    (EW),
      .CW    (CW),
      .IDX   (k),
      .TAG_W (TAG_W),
      .LAST  (k == STAGES - 1)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .flush     (flush_i),
      .in_valid  (v[k]),
      .in_mode   (m[k]),
      .in_tag    (t[k]),
      .in_acc    (acc[k]),
      .in_a      (a[k]),
      .in_b      (b[k]),
      .out_valid (v[k+1]),
      .out_mode  (m[k+1]),
      .out_tag   (t[k+1]),
      .out_acc   (acc[k+1]),
      .out_a     (a[k+1]),
      .out_b     (b[k+1])
    );
  end

  assign valid_o   = v[STAGES];
  assign tag_o     = t[STAGES];
  assign product_o = hi_select(m[STAGES]) ? acc[STAGES][2*WIDTH-1:WIDTH] : acc[STAGES][WIDTH-1:0];

  always_comb begin
    busy_o = 1'b0;
    for (int k = 1; k <= STAGES; k++) busy_o = busy_o | v[k];
  end

  logic unused_bits;
  assign unused_bits = ^{a[STAGES], b[STAGES], acc[STAGES][2*EW-1:2*WIDTH]};

endmodule

// File: tb/tb_pipe_mult_rv.sv
// tb/tb_pipe_mult_rv.sv - randomized scoreboard bench for pipe_mult_rv
module tb_pipe_mult_rv;

  localparam int W      = 32;
  localparam int STAGES = 8;
  localparam int TAG_W  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_i;
  logic             ready_o;
  logic [1:0]       mode_i;
  logic [W-1:0]     multiplier_i;
  logic [W-1:0]     multicand_i;
  logic [TAG_W-1:0] tag_i;
  logic             flush_i;
  logic             valid_o;
  logic             ready_i;
  logic [W-1:0]     product_o;
  logic [TAG_W-1:0] tag_o;
  logic             busy_o;

  pipe_mult_rv #(.WIDTH(W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .mode_i       (mode_i),
    .multiplier_i (multiplier_i),
    .multicand_i  (multicand_i),
    .tag_i        (tag_i),
    .flush_i      (flush_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .product_o    (product_o),
    .tag_o        (tag_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact integer product of the operands as the mode interprets them.
  function automatic logic [W-1:0] ref_mult(input logic [1:0] m, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
    logic [2*W+1:0] xe, ye, p;
    logic sx, sy;
    sx = (m == 2'b01) || (m == 2'b10);
    sy = (m == 2'b01);
    xe = (sx && x[W-1]) ? {{(W+2){1'b1}}, x} : {{(W+2){1'b0}}, x};
    ye = (sy && y[W-1]) ? {{(W+2){1'b1}}, y} : {{(W+2){1'b0}}, y};
    p  = xe * ye;
    return (m == 2'b00) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return r[W-1:0];
    endcase
  endfunction

  typedef struct packed {
    logic [W-1:0]     p;
    logic [TAG_W-1:0] t;
  } exp_t;

  exp_t             q[$];
  logic             prev_stall = 1'b0;
  logic [W-1:0]     prev_prod;
  logic [TAG_W-1:0] prev_tag;

  // Compare process: inputs settle at negedge, so #2 later shows exactly what the next edge sees.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      q.delete();
      chk("ready_low_in_reset", {63'd0, ready_o}, 64'd0);
    end else begin
      chk("ready_rule", {63'd0, ready_o}, {63'd0, !(valid_o && !ready_i)});
      if (prev_stall) begin
        chk("stall_hold_valid", {63'd0, valid_o}, 64'd1);
        chk("stall_hold_product", {32'd0, product_o}, {32'd0, prev_prod});
        chk("stall_hold_tag", {60'd0, tag_o}, {60'd0, prev_tag});
      end
      if (valid_o && ready_i) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got tag %h product %h with nothing outstanding", tag_o, product_o);
        end else begin
          e = q.pop_front();
          chk("result_product", {32'd0, product_o}, {32'd0, e.p});
          chk("result_tag", {60'd0, tag_o}, {60'd0, e.t});
        end
      end
      if (flush_i) q.delete();
      else if (valid_i && ready_o)
        q.push_back('{p: ref_mult(mode_i, multiplier_i, multicand_i), t: tag_i});
    end
    prev_stall = !rst && !flush_i && valid_o && !ready_i;
    prev_prod  = product_o;
    prev_tag   = tag_o;
  end

  task automatic run_one(input logic [1:0] m, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [TAG_W-1:0] tg, input logic [W-1:0] exp_p);
    int lat;
    @(negedge clk);
    valid_i = 1'b1; mode_i = m; multiplier_i = x; multicand_i = y; tag_i = tg; ready_i = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      valid_i = 1'b0;
    end while (!valid_o && lat < 100);
    chk("direct_latency", 64'(lat), 64'(STAGES));
    chk("direct_product", {32'd0, product_o}, {32'd0, exp_p});
    chk("direct_tag", {60'd0, tag_o}, {60'd0, tg});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int acc_n, cyc, highs;
    logic pending;
    logic [TAG_W-1:0] next_tag;

    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0;
    mode_i = '0; multiplier_i = '0; multicand_i = '0; tag_i = '0;

    chk("model_mulhu", {32'd0, ref_mult(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF)}, 64'hFFFFFFFE);
    chk("model_mul", {32'd0, ref_mult(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF)}, 64'h00000001);
    chk("model_mulh", {32'd0, ref_mult(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF)}, 64'h00000000);
    chk("model_mulhsu", {32'd0, ref_mult(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF)}, 64'hFFFFFFFF);
    chk("model_mulh_min", {32'd0, ref_mult(2'b01, 32'h80000000, 32'h80000000)}, 64'h40000000);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid_o", {63'd0, valid_o}, 64'd0);
    chk("reset_busy_o", {63'd0, busy_o}, 64'd0);
    chk("reset_ready_o", {63'd0, ready_o}, 64'd0);
    chk("reset_product_o", {32'd0, product_o}, 64'd0);
    chk("reset_tag_o", {60'd0, tag_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {63'd0, ready_o}, 64'd1);

    run_one(2'b00, 32'd2, 32'd3, 4'd5, 32'd6);
    run_one(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1, 32'hFFFFFFFE);
    run_one(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2, 32'h00000001);
    run_one(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3, 32'h00000000);
    run_one(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd4, 32'hFFFFFFFF);
    run_one(2'b01, 32'h80000000, 32'h80000000, 4'd6, 32'h40000000);

    // Back-to-back random ops with random consumer backpressure.
    acc_n = 0; cyc = 0; pending = 1'b0; next_tag = '0;
    while (acc_n < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (!pending) begin
        mode_i = 2'($urandom_range(0, 3));
        multiplier_i = rnd_op();
        multicand_i = rnd_op();
        tag_i = next_tag;
      end
      valid_i = 1'b1;
      ready_i = 1'($urandom_range(0, 1));
      #1;
      if (ready_o) begin
        acc_n++;
        next_tag = next_tag + 1'b1;
        pending = 1'b0;
      end else begin
        pending = 1'b1;
      end
    end
    chk("random_ops_accepted", 64'(acc_n), 64'd1000);
    @(negedge clk);
    valid_i = 1'b0; ready_i = 1'b1;
    repeat (STAGES + 2) @(negedge clk);
    #3;
    chk("random_drain_empty", 64'(q.size()), 64'd0);

    // Fill the pipe, then flush with an op offered in the same cycle.
    for (int i = 0; i < STAGES; i++) begin
      @(negedge clk);
      valid_i = 1'b1; mode_i = 2'($urandom_range(0, 3));
      multiplier_i = rnd_op(); multicand_i = rnd_op(); tag_i = 4'd9; ready_i = 1'b1;
    end
    @(negedge clk);
    flush_i = 1'b1; valid_i = 1'b1; tag_i = 4'd10;
    @(posedge clk); #1;
    chk("flush_valid_o", {63'd0, valid_o}, 64'd0);
    chk("flush_busy_o", {63'd0, busy_o}, 64'd0);
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0;
    run_one(2'b01, 32'h80000000, 32'h80000000, 4'd11, 32'h40000000);

    // Reset while stalled with ops in flight.
    for (int i = 0; i < STAGES + 3; i++) begin
      @(negedge clk);
      valid_i = 1'b1; mode_i = 2'b00; multiplier_i = rnd_op(); multicand_i = rnd_op();
      tag_i = 4'd12; ready_i = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1; valid_i = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid_o", {63'd0, valid_o}, 64'd0);
    chk("midrst_product_o", {32'd0, product_o}, 64'd0);
    chk("midrst_tag_o", {60'd0, tag_o}, 64'd0);
    chk("midrst_busy_o", {63'd0, busy_o}, 64'd0);
    chk("midrst_ready_o", {63'd0, ready_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0; ready_i = 1'b1;
    highs = 0;
    repeat (2 * STAGES) begin
      @(negedge clk); #1;
      if (valid_o) highs++;
    end
    chk("midrst_no_stale", 64'(highs), 64'd0);

    run_one(2'b10, 32'hFFFFFFFE, 32'd3, 4'd13, 32'hFFFFFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
